// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel selector.
// The state encoding is fixed at 2 bits so downstream debug taps stay stable.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // A 1-channel selector still needs a 1-bit select so that port widths stay legal.
  function automatic int tree_depth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_tree.sv
// Combinational N_CH:1 selector built as a balanced tree of 2:1 nodes.
// Leaves past N_CH-1 are tied to zero so that a non-power-of-2 channel count is handled.
module mux_tree
  import scan_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = tree_depth(N_CH)
) (
  input  logic [N_CH*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      dout
);

  // Level 0 is the root and level SEL_W holds the leaves. Level d is steered by sel[SEL_W-1-d].
  for (genvar d = 0; d <= SEL_W; d++) begin : g_lvl
    logic [DATA_W-1:0] node [1 << d];
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      if (d == SEL_W) begin : g_leaf
        if (j < N_CH) begin : g_used
          assign node[j] = din[j*DATA_W +: DATA_W];
        end else begin : g_tied
          assign node[j] = '0;
        end
      end else begin : g_mux
        assign node[j] = sel[SEL_W-1-d] ? g_lvl[d+1].node[2*j+1] : g_lvl[d+1].node[2*j];
      end
    end
  end

  assign dout = g_lvl[0].node[0];

endmodule

// File: rtl/scan_mux.sv
// N_CH:1 channel selector with a registered output. The select comes either from a
// loaded value (manual mode) or from a round-robin counter (auto-scan mode).
//
//   state | meaning
//   IDLE  | en low: the output holds, dout_valid is low, and sel moves only on a load
//   MAN   | manual: sel holds unless it is loaded; the output tracks din[sel]
//   SCAN  | auto-scan: sel steps by one each cycle and wraps N_CH-1 -> 0
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = tree_depth(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] din,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   sel_load,
  output logic [DATA_W-1:0]      dout,
  output logic [SEL_W-1:0]       dout_ch,
  output logic                   dout_valid,
  output logic                   scan_wrap,
  output logic                   sel_err
);

  localparam logic [SEL_W:0]   N_CH_V   = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic              wrap_nxt, err_nxt;
  logic [DATA_W-1:0] mux_out;

  mux_tree #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_tree (
    .din  (din),
    .sel  (sel),
    .dout (mux_out)
  );

  always_comb begin
    state_nxt = IDLE;
    sel_nxt   = sel;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : MAN;
    // Any load, including an out-of-range one, blocks the scan step for that cycle.
    if (sel_load) begin
      if ({1'b0, sel_in} < N_CH_V) sel_nxt = sel_in;
      else                         err_nxt = 1'b1;
    end else if (state == SCAN) begin
      if (sel == SEL_LAST) begin
        sel_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        sel_nxt = sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      scan_wrap  <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      scan_wrap  <= wrap_nxt;
      sel_err    <= err_nxt;
      dout_valid <= (state != IDLE);
      if (state != IDLE) begin
        dout    <= mux_out;
        dout_ch <= sel;
      end
    end
  end

endmodule
